// File: rtl/pipe_run_ctrl.sv
// Run/load controller for the five-stage pipeline: fills instruction RAM from a
// byte stream, purges the pipeline latches, then sequences free run, single step and halt.
module pipe_run_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int CYC_W     = 32,
    parameter int FLUSH_CYC = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_code,
    input  logic [ADDR_W:0]   cmd_arg,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              halt_instr,
    output logic              pipe_en,
    output logic              flush,
    output logic [CYC_W-1:0]  cycle_cnt,
    output logic [2:0]        state,
    output logic              done
);

    // Command handshake: a command transfers at a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is decoded from state alone, so it never
    // depends on cmd_valid in the same cycle.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        STEP  = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RUN   = 3'd2;
    localparam logic [2:0] CMD_STEP  = 3'd3;
    localparam logic [2:0] CMD_HALT  = 3'd4;
    localparam logic [2:0] CMD_CLEAR = 3'd5;

    localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

    state_t              stateQ;
    state_t              stateNext;
    logic                doneNext;

    logic [ADDR_W:0]     wordTarget;
    logic [ADDR_W:0]     wordCnt;
    logic [ADDR_W:0]     wordCntInc;
    logic [1:0]          byteIdx;
    logic [23:0]         asmWord;
    logic [ADDR_W-1:0]   addrQ;
    logic                weQ;
    logic [31:0]         wdataQ;
    logic                flushQ;
    logic                doneQ;
    logic [FLUSH_W-1:0]  flushCnt;
    logic [CYC_W-1:0]    cntQ;

    logic                cmdFire;
    logic                cmdIdle;
    logic                loadStart;
    logic                clearCnt;
    logic                byteTake;
    logic                cntInc;

    assign cmdFire    = cmd_valid && cmd_ready;
    assign cmdIdle    = (stateQ == IDLE) || (stateQ == HALT);
    assign loadStart  = cmdFire && cmdIdle && (cmd_code == CMD_LOAD);
    assign clearCnt   = cmdFire && (cmd_code == CMD_CLEAR);
    assign wordCntInc = wordCnt + 1'b1;

    // Bytes are only taken while the load stays open; the edge that closes it
    // (end of the final write pulse) ignores any stray byte.
    assign byteTake   = byte_valid && (stateQ == LOAD) && (stateNext == LOAD);

    assign cmd_ready  = (stateQ == IDLE) || (stateQ == HALT) || (stateQ == RUN);
    assign pipe_en    = (stateQ == FLUSH) || (stateQ == RUN) || (stateQ == STEP);
    assign cntInc     = pipe_en && (stateQ != FLUSH) && (cntQ != {CYC_W{1'b1}});

    assign imem_we    = weQ;
    assign imem_addr  = addrQ;
    assign imem_wdata = wdataQ;
    assign flush      = flushQ;
    assign done       = doneQ;
    assign cycle_cnt  = cntQ;
    assign state      = stateQ;

    always_comb begin
        stateNext = stateQ;
        doneNext  = 1'b0;
        case (stateQ)
            IDLE, HALT: begin
                if (cmdFire) begin
                    case (cmd_code)
                        CMD_LOAD: stateNext = (cmd_arg == '0) ? FLUSH : LOAD;
                        CMD_RUN:  stateNext = RUN;
                        CMD_STEP: stateNext = STEP;
                        default:  stateNext = stateQ;
                    endcase
                end
            end
            LOAD: begin
                if (weQ && (wordCntInc == wordTarget)) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH: begin
                if (flushCnt == FLUSH_LAST) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            RUN: begin
                // A HALT command and halt_instr on the same edge fold into one transition.
                if (halt_instr || (cmdFire && (cmd_code == CMD_HALT))) begin
                    stateNext = HALT;
                    doneNext  = 1'b1;
                end
            end
            STEP: begin
                stateNext = HALT;
                doneNext  = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= IDLE;
            doneQ    <= 1'b0;
            flushQ   <= 1'b0;
            flushCnt <= '0;
        end else begin
            stateQ   <= stateNext;
            doneQ    <= doneNext;
            flushQ   <= (stateNext == FLUSH);
            flushCnt <= (stateQ == FLUSH) ? flushCnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wordTarget <= '0;
            wordCnt    <= '0;
            byteIdx    <= '0;
            asmWord    <= '0;
            addrQ      <= '0;
            weQ        <= 1'b0;
            wdataQ     <= '0;
        end else begin
            weQ <= 1'b0;
            if (loadStart) begin
                wordTarget <= cmd_arg;
                wordCnt    <= '0;
                byteIdx    <= '0;
                addrQ      <= '0;
            end else if (stateQ == LOAD) begin
                // The write pulse uses the current address; advance once it has been issued.
                if (weQ) begin
                    addrQ   <= addrQ + 1'b1;
                    wordCnt <= wordCntInc;
                end
                if (byteTake) begin
                    byteIdx <= byteIdx + 1'b1;
                    case (byteIdx)
                        2'd0: asmWord[7:0]   <= byte_data;
                        2'd1: asmWord[15:8]  <= byte_data;
                        2'd2: asmWord[23:16] <= byte_data;
                        default: begin
                            wdataQ <= {byte_data, asmWord};
                            weQ    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntQ <= '0;
        end else if (loadStart || clearCnt) begin
            cntQ <= '0;
        end else if (cntInc) begin
            cntQ <= cntQ + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: command table plus hand sequences for load, run/halt,
// step, reset-mid-load and counter saturation (second instance with a 4-bit counter).
module tb_pipe_run_ctrl;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_code;
    logic [ADDR_W:0]   cmd_arg;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              halt_instr;
    logic              pipe_en;
    logic              flush;
    logic [31:0]       cycle_cnt;
    logic [2:0]        state;
    logic              done;

    logic              cmd_ready4;
    logic              imem_we4;
    logic [ADDR_W-1:0] imem_addr4;
    logic [31:0]       imem_wdata4;
    logic              pipe_en4;
    logic              flush4;
    logic [3:0]        cycle_cnt4;
    logic [2:0]        state4;
    logic              done4;

    pipe_run_ctrl #(.ADDR_W(ADDR_W), .CYC_W(32), .FLUSH_CYC(3)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .byte_valid(byte_valid),
        .byte_data(byte_data), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .halt_instr(halt_instr), .pipe_en(pipe_en),
        .flush(flush), .cycle_cnt(cycle_cnt), .state(state), .done(done)
    );

    pipe_run_ctrl #(.ADDR_W(ADDR_W), .CYC_W(4), .FLUSH_CYC(3)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .byte_valid(byte_valid),
        .byte_data(byte_data), .imem_we(imem_we4), .imem_addr(imem_addr4),
        .imem_wdata(imem_wdata4), .halt_instr(halt_instr), .pipe_en(pipe_en4),
        .flush(flush4), .cycle_cnt(cycle_cnt4), .state(state4), .done(done4)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    // scoreboard
    logic [40:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int pe_cnt   = 0;
    int flush_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL imem_we_unexpected: write addr %0d data 0x%08h, expected none",
                             imem_addr, imem_wdata);
                end else begin
                    chk("imem_write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
                end
            end
            if (done) done_cnt++;
            if (pipe_en) pe_cnt++;
            if (flush) begin
                flush_cnt++;
                chk("pipe_en_in_flush", 64'(pipe_en), 64'd1);
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic [2:0] code, input logic [ADDR_W:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(state), 64'(s));
    endtask

    typedef struct {
        logic [2:0]      code;
        logic [ADDR_W:0] arg;
        logic [2:0]      exp_state;
        logic            exp_ready;
        logic            exp_pe;
        logic            chk_cnt;
        logic [31:0]     exp_cnt;
    } vec_t;

    vec_t vecs[11];
    logic [7:0] load_bytes[8];

    initial begin
        int base_done, base_pe, base_wr, base_flush;
        logic [31:0] base_cnt;

        vecs[0]  = '{3'd5, 10'd0, 3'd5, 1'b1, 1'b0, 1'b1, 32'd0}; // CLEAR_CNT in HALT
        vecs[1]  = '{3'd4, 10'd0, 3'd5, 1'b1, 1'b0, 1'b1, 32'd0}; // HALT in HALT ignored
        vecs[2]  = '{3'd7, 10'd0, 3'd5, 1'b1, 1'b0, 1'b1, 32'd0}; // unknown code
        vecs[3]  = '{3'd0, 10'd0, 3'd5, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{3'd3, 10'd0, 3'd4, 1'b0, 1'b1, 1'b1, 32'd0}; // STEP
        vecs[5]  = '{3'd6, 10'd0, 3'd5, 1'b1, 1'b0, 1'b1, 32'd1}; // back in HALT
        vecs[6]  = '{3'd2, 10'd0, 3'd3, 1'b1, 1'b1, 1'b1, 32'd1}; // RUN
        vecs[7]  = '{3'd1, 10'd2, 3'd3, 1'b1, 1'b1, 1'b0, 32'd0}; // LOAD dropped in RUN
        vecs[8]  = '{3'd3, 10'd0, 3'd3, 1'b1, 1'b1, 1'b0, 32'd0}; // STEP dropped in RUN
        vecs[9]  = '{3'd5, 10'd0, 3'd3, 1'b1, 1'b1, 1'b1, 32'd0}; // CLEAR_CNT beats increment
        vecs[10] = '{3'd4, 10'd0, 3'd5, 1'b1, 1'b0, 1'b1, 32'd2}; // HALT command
        load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

        reset = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_arg = '0;
        byte_valid = 1'b0; byte_data = '0; halt_instr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_ready", 64'(cmd_ready), 64'd1);
        chk("reset_outs", 64'({pipe_en, flush, done, imem_we}), 64'd0);
        chk("reset_cnt", 64'(cycle_cnt), 64'd0);
        chk("reset_addr_data", 64'({imem_addr, imem_wdata}), 64'd0);

        // RUN, halt_instr sampled at the 10th edge of RUN
        base_pe = pe_cnt; base_done = done_cnt;
        send_cmd(3'd2, '0);
        chk("run_state", 64'(state), 64'd3);
        repeat (9) @(negedge clk);
        halt_instr = 1'b1;
        @(negedge clk);
        halt_instr = 1'b0;
        chk("halt_instr_state", 64'(state), 64'd5);
        chk("halt_instr_pe_now", 64'(pipe_en), 64'd0);
        @(negedge clk);
        chk("run_pe_cycles", 64'(pe_cnt - base_pe), 64'd10);
        chk("run_cnt", 64'(cycle_cnt), 64'd10);
        chk("run_done", 64'(done_cnt - base_done), 64'd1);

        // three single steps from HALT
        base_pe = pe_cnt; base_done = done_cnt;
        for (int i = 0; i < 3; i++) begin
            send_cmd(3'd3, '0);
            chk("step_state", 64'(state), 64'd4);
        end
        repeat (2) @(negedge clk);
        chk("step_pe_cycles", 64'(pe_cnt - base_pe), 64'd3);
        chk("step_cnt", 64'(cycle_cnt), 64'd13);
        chk("step_done", 64'(done_cnt - base_done), 64'd3);
        chk("step_end_state", 64'(state), 64'd5);

        // command table
        base_done = done_cnt;
        for (int i = 0; i < 11; i++) begin
            send_cmd(vecs[i].code, vecs[i].arg);
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].exp_state));
            chk($sformatf("vec%0d_ready", i), 64'(cmd_ready), 64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_pipe_en", i), 64'(pipe_en), 64'(vecs[i].exp_pe));
            if (vecs[i].chk_cnt) chk($sformatf("vec%0d_cnt", i), 64'(cycle_cnt), 64'(vecs[i].exp_cnt));
        end
        @(negedge clk);
        chk("table_done", 64'(done_cnt - base_done), 64'd2);

        // HALT command and halt_instr on the same edge
        base_done = done_cnt;
        send_cmd(3'd2, '0);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1; cmd_code = 3'd4; halt_instr = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; halt_instr = 1'b0;
        repeat (3) @(negedge clk);
        chk("dual_halt_state", 64'(state), 64'd5);
        chk("dual_halt_done", 64'(done_cnt - base_done), 64'd1);

        // LOAD two words
        base_done = done_cnt; base_wr = wr_cnt; base_flush = flush_cnt;
        exp_q.push_back({9'd0, 32'h44332211});
        exp_q.push_back({9'd1, 32'hDDCCBBAA});
        send_cmd(3'd1, 10'd2);
        chk("load_state", 64'(state), 64'd1);
        chk("load_ready", 64'(cmd_ready), 64'd0);
        chk("load_cnt_zeroed", 64'(cycle_cnt), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = load_bytes[i];
        end
        @(negedge clk);
        byte_valid = 1'b0;
        wait_state(3'd2, 10, "load_to_flush");
        wait_state(3'd0, 10, "flush_to_idle");
        @(negedge clk);
        chk("load_writes", 64'(wr_cnt - base_wr), 64'd2);
        chk("load_flush_cycles", 64'(flush_cnt - base_flush), 64'd3);
        chk("load_done", 64'(done_cnt - base_done), 64'd1);
        chk("load_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("load_cnt_after", 64'(cycle_cnt), 64'd0);

        // LOAD with zero words
        base_done = done_cnt; base_wr = wr_cnt; base_flush = flush_cnt;
        send_cmd(3'd1, 10'd0);
        chk("load0_state", 64'(state), 64'd2);
        chk("load0_flush", 64'(flush), 64'd1);
        wait_state(3'd0, 10, "load0_to_idle");
        @(negedge clk);
        chk("load0_flush_cycles", 64'(flush_cnt - base_flush), 64'd3);
        chk("load0_writes", 64'(wr_cnt - base_wr), 64'd0);
        chk("load0_done", 64'(done_cnt - base_done), 64'd1);

        // reset in the middle of a LOAD, after 6 bytes
        base_wr = wr_cnt;
        exp_q.push_back({9'd0, 32'h04030201});
        send_cmd(3'd1, 10'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'(i + 1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_load_state", 64'(state), 64'd0);
        chk("rst_load_ready", 64'(cmd_ready), 64'd1);
        chk("rst_load_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_load_we", 64'(imem_we), 64'd0);
        repeat (10) @(negedge clk);
        chk("rst_load_writes", 64'(wr_cnt - base_wr), 64'd1);
        chk("rst_load_queue_empty", 64'(exp_q.size()), 64'd0);

        // saturation: 20 running cycles
        base_cnt = cycle_cnt;
        send_cmd(3'd5, '0);
        send_cmd(3'd2, '0);
        repeat (18) @(negedge clk);
        send_cmd(3'd4, '0);
        @(negedge clk);
        chk("sat_cnt32", 64'(cycle_cnt), 64'd20);
        chk("sat_cnt4", 64'(cycle_cnt4), 64'd15);
        chk("sat_state", 64'(state), 64'd5);
        chk("sat_state4", 64'(state4), 64'd5);
        chk("sat_base_cleared", 64'(base_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
